adc_fill_reader: RTL



---
 rtl/adc_readout_pkg.sv | 31 +++
 rtl/adc_word_serializer.sv | 74 +++++++
 rtl/adc_fill_reader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/adc_readout_pkg.sv
// Shared definitions for the fill readout path.
// Header field positions, lane count, reader state encoding and the checksum fold
// applied to every data word.
package adc_readout_pkg;

  localparam int unsigned WORD_W  = 128;
  localparam int unsigned LANES   = 4;

  // Header field LSB positions and widths
  localparam int unsigned FN_LSB  = 0;
  localparam int unsigned FN_W    = 24;
  localparam int unsigned ADR_LSB = 24;
  localparam int unsigned NB_LSB  = 47;
  localparam int unsigned FT_LSB  = 68;
  localparam int unsigned FT_W    = 2;
  localparam int unsigned TAG_LSB = 70;
  localparam int unsigned TAG_W   = 16;

  // Reader state encoding
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHdr   = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StCsum  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  // XOR of the four 32-bit lanes of one word
  function automatic logic [31:0] csum_fold(input logic [WORD_W-1:0] w);
    return w[31:0] ^ w[63:32] ^ w[95:64] ^ w[127:96];
  endfunction

endpackage

// File: rtl/adc_word_serializer.sv
// 128-bit to OutW-bit lane shifter with valid/ready handshake.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   load_i, word_i  capture a new word (lane 0 goes out first)
//   sof_i, eof_i    tag the loaded word as header / checksum word
//   ready_i         downstream accept
//   data_o, valid_o current lane and its valid flag (data is 0 while idle)
//   sof_o, eof_o    lane 0 of a header word / last lane of a checksum word
//   empty_o         no word held
//   can_load_o      a word may be loaded this cycle without losing a lane
module adc_word_serializer
  import adc_readout_pkg::*;
#(
  parameter int unsigned OutW = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              sof_i,
  input  logic              eof_i,
  input  logic              ready_i,
  output logic [OutW-1:0]   data_o,
  output logic              valid_o,
  output logic              sof_o,
  output logic              eof_o,
  output logic              empty_o,
  output logic              can_load_o
);

  localparam int unsigned Lanes = WORD_W / OutW;
  localparam int unsigned LaneW = $clog2(Lanes);
  localparam logic [LaneW-1:0] LastLane = LaneW'(Lanes - 1);

  logic [WORD_W-1:0] word_q;
  logic [LaneW-1:0]  lane_q;
  logic              valid_q;
  logic              sof_q;
  logic              eof_q;
  logic              last_beat;

  assign last_beat  = valid_q & ready_i & (lane_q == LastLane);
  // Reloading on the final accepted lane keeps the stream bubble-free
  assign can_load_o = !valid_q | last_beat;
  assign empty_o    = !valid_q;
  assign valid_o    = valid_q;
  assign sof_o      = valid_q & sof_q & (lane_q == '0);
  assign eof_o      = valid_q & eof_q & (lane_q == LastLane);

  always_comb begin
    data_o = '0;
    if (valid_q) data_o = word_q[int'(lane_q) * OutW +: OutW];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q  <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else if (load_i) begin
      word_q  <= word_i;
      lane_q  <= '0;
      valid_q <= 1'b1;
      sof_q   <= sof_i;
      eof_q   <= eof_i;
    end else if (valid_q && ready_i) begin
      if (lane_q == LastLane) valid_q <= 1'b0;
      else                    lane_q  <= lane_q + LaneW'(1);
    end
  end

endmodule

// File: rtl/adc_fill_reader.sv
// Drains one stored fill (header, N data words, checksum word) from an FWFT read
// FIFO, latches the header fields, verifies the checksum and streams every word out
// as 32-bit lanes.
// Ports:
//   clk, reset                 readout clock, synchronous active-high reset
//   readout_start              start one fill (ignored while busy)
//   fifo_dout/empty/rd_en      FWFT read-FIFO interface
//   out_data/valid/ready       serialized output stream
//   out_sof, out_eof           first lane of header / last lane of checksum word
//   fill_num, num_fill_bursts, channel_tag, fill_type   latched header fields
//   checksum_err               sticky mismatch flag, cleared by readout_start
//   readout_busy, readout_done not idle / one-cycle end-of-fill pulse
module adc_fill_reader
  import adc_readout_pkg::*;
#(
  parameter int unsigned NBURST_W = 21,
  parameter int unsigned OUT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                readout_start,
  input  logic [WORD_W-1:0]   fifo_dout,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sof,
  output logic                out_eof,
  output logic [FN_W-1:0]     fill_num,
  output logic [NBURST_W-1:0] num_fill_bursts,
  output logic [TAG_W-1:0]    channel_tag,
  output logic [FT_W-1:0]     fill_type,
  output logic                checksum_err,
  output logic                readout_busy,
  output logic                readout_done
);

  logic [2:0]          state_q, state_d;
  logic [NBURST_W-1:0] cnt_q, cnt_d;
  logic [31:0]         acc_q, acc_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic [FN_W-1:0]     fn_q, fn_d;
  logic [NBURST_W-1:0] nb_q, nb_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [FT_W-1:0]     ft_q, ft_d;
  logic                ser_empty;
  logic                ser_can_load;
  logic [NBURST_W-1:0] hdr_nb;

  assign hdr_nb = fifo_dout[NB_LSB +: NBURST_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    err_d   = err_q;
    done_d  = 1'b0;
    fn_d    = fn_q;
    nb_d    = nb_q;
    tag_d   = tag_q;
    ft_d    = ft_q;

    fifo_rd_en = ((state_q == StHdr) || (state_q == StData) || (state_q == StCsum)) &&
                 !fifo_empty && ser_can_load;

    case (state_q)
      StIdle: begin
        if (readout_start) begin
          err_d   = 1'b0;
          acc_d   = '0;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (fifo_rd_en) begin
          fn_d    = fifo_dout[FN_LSB +: FN_W];
          nb_d    = hdr_nb;
          tag_d   = fifo_dout[TAG_LSB +: TAG_W];
          ft_d    = fifo_dout[FT_LSB +: FT_W];
          cnt_d   = hdr_nb;
          state_d = (hdr_nb == '0) ? StCsum : StData;
        end
      end
      StData: begin
        if (fifo_rd_en) begin
          acc_d = acc_q ^ csum_fold(fifo_dout);
          cnt_d = cnt_q - NBURST_W'(1);
          if (cnt_q == NBURST_W'(1)) state_d = StCsum;
        end
      end
      StCsum: begin
        if (fifo_rd_en) begin
          // Upper 96 bits of the checksum word must be zero as well
          err_d   = (fifo_dout != {96'b0, acc_q});
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (ser_empty) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      fn_q    <= '0;
      nb_q    <= '0;
      tag_q   <= '0;
      ft_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      done_q  <= done_d;
      fn_q    <= fn_d;
      nb_q    <= nb_d;
      tag_q   <= tag_d;
      ft_q    <= ft_d;
    end
  end

  adc_word_serializer #(
    .OutW (OUT_W)
  ) u_ser (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (fifo_rd_en),
    .word_i     (fifo_dout),
    .sof_i      (state_q == StHdr),
    .eof_i      (state_q == StCsum),
    .ready_i    (out_ready),
    .data_o     (out_data),
    .valid_o    (out_valid),
    .sof_o      (out_sof),
    .eof_o      (out_eof),
    .empty_o    (ser_empty),
    .can_load_o (ser_can_load)
  );

  assign fill_num        = fn_q;
  assign num_fill_bursts = nb_q;
  assign channel_tag     = tag_q;
  assign fill_type       = ft_q;
  assign checksum_err    = err_q;
  assign readout_busy    = (state_q != StIdle);
  assign readout_done    = done_q;

endmodule
